seq_mult_16: RTL and testbench

//  Sequential 16x16 unsigned shift-and-add multiplier. The partial-product adder
//  is one cla_16 instance: operands on x/y, c0 tied 0, sum on s, carry-out c16.

---
 rtl/arith_pkg.sv | 12 +
 rtl/cla_16.sv | 37 +++
 rtl/seq_mult_16.sv | 124 ++++++++++++
 tb/tb_seq_mult_16.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared widths and FSM encoding for the sequential multiplier and its adder.
package arith_pkg;
  localparam int WIDTH  = 16;
  localparam int PROD_W = 32;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/cla_16.sv
// 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
module cla_16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        c0,
  output logic [15:0] s,
  output logic        c16
);
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g     = x & y;
  assign p     = x ^ y;
  assign gc[0] = c0;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_grp
      localparam int B = 4 * gi;
      assign c[B]   = gc[gi];
      assign c[B+1] = g[B] | (p[B] & gc[gi]);
      assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[gi]);
      assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & gc[gi]);
      assign gg[gi] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign gp[gi] = &p[B+3:B];
      assign gc[gi+1] = gg[gi] | (gp[gi] & gc[gi]);
    end
  endgenerate

  assign s   = p ^ c;
  assign c16 = gc[4];
endmodule

// File: rtl/seq_mult_16.sv
// Sequential 16x16 unsigned shift-and-add multiplier with start/busy/done handshake.
// Define EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_mult_16
  import arith_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] p
);
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PROD_W-1:0]  p_q, p_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   add_s;
  logic               add_c16;
  logic [WIDTH:0]     sum17;
  logic [PROD_W:0]    shifted;
  logic               finish;
  logic [PROD_W-1:0]  p_fin;

  cla_16 u_cla (
    .x   (acc_q[WIDTH-1:0]),
    .y   (mcand_q),
    .c0  (1'b0),
    .s   (add_s),
    .c16 (add_c16)
  );

  // acc_q[16] is always zero after a shift, so acc_q equals {1'b0, acc_q[15:0]}.
  assign sum17   = mplr_q[0] ? {add_c16, add_s} : acc_q;
  assign shifted = {1'b0, sum17, mplr_q[WIDTH-1:1]};

`ifdef EARLY_TERM_EN
  logic [3:0]       rem_sh;
  logic [WIDTH-1:0] rem_mask;
  always_comb begin
    rem_sh   = 4'(WIDTH - 1) - cnt_q[3:0];
    rem_mask = (WIDTH'(1) << rem_sh) - WIDTH'(1);
    finish   = (cnt_q == CNT_W'(WIDTH - 1)) || ((shifted[WIDTH-1:0] & rem_mask) == '0);
    // Align the partial product as if the skipped iterations had shifted in zeros.
    p_fin    = PROD_W'(shifted >> rem_sh);
  end
`else
  assign finish = (cnt_q == CNT_W'(WIDTH - 1));
  assign p_fin  = shifted[PROD_W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d = a;
          acc_d   = '0;
          mplr_d  = b;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d  = shifted[PROD_W:WIDTH];
        mplr_d = shifted[WIDTH-1:0];
        cnt_d  = cnt_q + CNT_W'(1);
        if (finish) begin
          p_d     = p_fin;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;
endmodule

// File: tb/tb_seq_mult_16.sv
// Self-checking bench for seq_mult_16: vector table, corner sequences, random scoreboard.
module tb_seq_mult_16;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy;
  logic        done;
  logic [31:0] p;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  typedef struct {
    logic [31:0] p;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  seq_mult_16 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a_in),
    .b     (b_in),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] bv);
`ifdef EARLY_TERM_EN
    int m = 0;
    for (int i = 0; i < 16; i++) if (bv[i]) m = i;
    return m + 1;
`else
    return 16;
`endif
  endfunction

  // One operation; with noise, start is held and a/b scrambled through RUN and DONE.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                        input logic [31:0] pexp, input bit noise);
    exp_t e;
    int   n;
    int   busy_n;
    @(negedge clk);
    a_in  = av;
    b_in  = bv;
    start = 1'b1;
    e.p   = pexp;
    e.lat = exp_lat(bv);
    sb.push_back(e);
    @(negedge clk);
    n      = 1;
    busy_n = 0;
    start  = noise;
    if (noise) begin a_in = 16'($urandom); b_in = 16'($urandom); end
    while (!done && n < 40) begin
      if (busy) busy_n++;
      @(negedge clk);
      n++;
      start = noise;
      if (noise) begin a_in = 16'($urandom); b_in = 16'($urandom); end
    end
    if (busy) busy_n++;
    e = sb.pop_front();
    if (!done) begin
      check("done_timeout", 64'(n), 64'(e.lat + 1));
      start = 1'b0;
      return;
    end
    check("p", p, e.p);
    check("latency", 64'(n - 1), 64'(e.lat));
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
    check("p_hold", p, e.p);
    check("busy_cycles", 64'(busy_n), 64'(e.lat + 1));
    $display("op a=%04h b=%04h p=%08h lat=%0d noise=%0d", av, bv, p, n - 1, noise);
  endtask

  initial begin
    vec_t vecs[10];
    int   n;
    int   d1;
    int   dones;
    logic [15:0] ra, rb;
    logic [15:0] rst_b;

    vecs[0] = '{16'h0006, 16'h0009, 32'h0000_0036};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[2] = '{16'h0000, 16'hFFFF, 32'h0000_0000};
    vecs[3] = '{16'h1234, 16'h0001, 32'h0000_1234};
    vecs[4] = '{16'h0003, 16'h8000, 32'h0001_8000};
    vecs[5] = '{16'hFFFF, 16'h0000, 32'h0000_0000};
    vecs[6] = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};
    vecs[7] = '{16'h8000, 16'h8000, 32'h4000_0000};
    vecs[8] = '{16'hFFFF, 16'h8000, 32'h7FFF_8000};
    vecs[9] = '{16'h1234, 16'h5678, 32'h0626_0060};

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_p", p, 0);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p, 1'b0);

    // start pulsed throughout RUN and DONE must not disturb the result or timing.
    run_op(16'h00AB, 16'h00CD, 32'h0000_88EF, 1'b1);

    // Asynchronous reset in the middle of an operation.
`ifdef EARLY_TERM_EN
    rst_b = 16'h0909;
`else
    rst_b = 16'h0009;
`endif
    @(negedge clk);
    a_in = 16'h0007; b_in = rst_b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_midrun_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("rst_midrun_busy", busy, 0);
    check("rst_midrun_done", done, 0);
    check("rst_midrun_p", p, 0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("rst_no_done", 64'(dones), 0);
    $display("reset mid-run: p=%08h spurious_done=%0d", p, dones);

    // start held high: second operation accepted on the first IDLE edge after done.
    @(negedge clk);
    a_in = 16'h1357; b_in = 16'h8001; start = 1'b1;
    @(negedge clk);
    n = 1;
    while (!done && n < 40) begin @(negedge clk); n++; end
    check("held_p1", p, 32'h1357 * 32'h8001);
    d1 = n;
    @(negedge clk);
    n++;
    a_in = 16'h2468; b_in = 16'hC003;
    @(negedge clk);
    n++;
    start = 1'b0;
    while (!done && n < 80) begin @(negedge clk); n++; end
    check("held_p2", p, 32'h2468 * 32'hC003);
    check("held_gap", 64'(n - d1), 18);
    $display("start held: p2=%08h gap=%0d", p, n - d1);
    @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 8 == 1) rb = 16'($urandom_range(0, 15));
      run_op(ra, rb, {16'h0, ra} * {16'h0, rb}, (i % 4) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
